mem_stage_access: RTL

// - MEM-stage consumer of the EX/MEM latch: turns the latched mem_read/mem_write intent into a data-memory handshake.
// - Sequences LDI/STI (two accesses) and aligns LDB/STB byte lanes.
// - Stalls the upstream pipeline while memory is busy; feeds loaded data to the MEM/WB latch.

---
 rtl/mem_stage_access_pkg.sv | 23 ++
 rtl/mem_stage_access_if.sv | 23 ++
 rtl/mem_stage_access_byte_align.sv | 35 +++
 rtl/mem_stage_access.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_stage_access_pkg.sv
// Shared LC-3b types for the MEM stage: word and write-mask types, the access FSM states
// and a byte-lane mask helper.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IND  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } mem_access_state_t;

    localparam lc3b_mem_wmask WMASK_NONE = 2'b00;
    localparam lc3b_mem_wmask WMASK_WORD = 2'b11;

    // Odd byte addresses live in the high lane.
    function automatic lc3b_mem_wmask byte_wmask(input logic addr0);
        return addr0 ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_stage_access_if.sv
// Data-memory handshake bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_access_if;
    import lc3b_types::*;

    lc3b_word      dmem_address;
    logic          dmem_read;
    logic          dmem_write;
    lc3b_mem_wmask dmem_wmask;
    lc3b_word      dmem_wdata;
    lc3b_word      dmem_rdata;
    logic          dmem_resp;

    modport master (
        output dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp
    );

endinterface

// File: rtl/mem_stage_access_byte_align.sv
// Byte-lane alignment: lane select and extension for loads, lane replication and
// write mask for stores. Purely combinational.
module mem_byte_align
    import lc3b_types::*;
#(
    parameter bit LDB_SEXT = 1'b1
) (
    input  logic          st_byte_i,
    input  logic          st_addr0_i,
    input  lc3b_word      st_data_i,
    input  logic          ld_byte_i,
    input  logic          ld_addr0_i,
    input  lc3b_word      ld_rdata_i,
    output lc3b_mem_wmask wmask_o,
    output lc3b_word      wdata_o,
    output lc3b_word      ld_data_o
);

    logic [7:0] ld_lane;

    always_comb begin
        wmask_o = st_byte_i ? byte_wmask(st_addr0_i) : WMASK_WORD;
        wdata_o = st_byte_i ? {st_data_i[7:0], st_data_i[7:0]} : st_data_i;

        ld_lane = ld_addr0_i ? ld_rdata_i[15:8] : ld_rdata_i[7:0];
        if (!ld_byte_i) begin
            ld_data_o = ld_rdata_i;
        end else if (LDB_SEXT) begin
            ld_data_o = {{8{ld_lane[7]}}, ld_lane};
        end else begin
            ld_data_o = {8'h00, ld_lane};
        end
    end

endmodule

// File: rtl/mem_stage_access.sv
// MEM-stage access sequencer: turns EX/MEM load/store intent into data-memory
// handshakes (including LDI/STI pointer fetch), stalls upstream while busy.
//
// state | meaning
// IDLE  | no access in flight; a request is captured here
// IND   | pointer read for LDI/STI
// ACC   | final read or write access
// DONE  | one-cycle completion pulse, EX/MEM advances
module mem_stage_access
    import lc3b_types::*;
#(
    parameter bit LDB_SEXT = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_read_in,
    input  logic                      mem_write_in,
    input  logic                      indirect_in,
    input  logic                      byte_in,
    input  lc3b_word                  addr_in,
    input  lc3b_word                  store_data_in,
    mem_stage_access_if.master        dmem,
    output lc3b_word                  mem_data_out,
    output logic                      done,
    output logic                      stall
);

    mem_access_state_t state_q;
    lc3b_word          addr_q;
    lc3b_word          sdata_q;
    logic              is_read_q;
    logic              byte_q;
    logic              read_q;
    logic              write_q;
    lc3b_mem_wmask     wmask_q;
    lc3b_word          wdata_q;
    lc3b_word          data_q;
    logic              done_q;

    logic              request;
    logic              nxt_byte;
    logic              nxt_addr0;
    lc3b_word          nxt_sdata;
    lc3b_mem_wmask     st_wmask;
    lc3b_word          st_wdata;
    lc3b_word          ld_data;

    assign request = mem_read_in | mem_write_in;

    // Store lane setup for the access about to start: either straight from EX/MEM,
    // or from the pointer arriving at the end of IND (indirect is always word-wide).
    always_comb begin
        nxt_byte  = byte_in & ~indirect_in;
        nxt_addr0 = addr_in[0];
        nxt_sdata = store_data_in;
        if (state_q == IND) begin
            nxt_byte  = 1'b0;
            nxt_addr0 = dmem.dmem_rdata[0];
            nxt_sdata = sdata_q;
        end
    end

    mem_byte_align #(
        .LDB_SEXT (LDB_SEXT)
    ) u_align (
        .st_byte_i  (nxt_byte),
        .st_addr0_i (nxt_addr0),
        .st_data_i  (nxt_sdata),
        .ld_byte_i  (byte_q),
        .ld_addr0_i (addr_q[0]),
        .ld_rdata_i (dmem.dmem_rdata),
        .wmask_o    (st_wmask),
        .wdata_o    (st_wdata),
        .ld_data_o  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            sdata_q   <= '0;
            is_read_q <= 1'b0;
            byte_q    <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            wmask_q   <= WMASK_NONE;
            wdata_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (request) begin
                        addr_q    <= addr_in;
                        sdata_q   <= store_data_in;
                        is_read_q <= mem_read_in;
                        byte_q    <= byte_in & ~indirect_in;
                        if (indirect_in) begin
                            state_q <= IND;
                            read_q  <= 1'b1;
                        end else begin
                            state_q <= ACC;
                            read_q  <= mem_read_in;
                            write_q <= ~mem_read_in;
                            wmask_q <= mem_read_in ? WMASK_NONE : st_wmask;
                            wdata_q <= st_wdata;
                        end
                    end
                end
                IND: begin
                    if (dmem.dmem_resp) begin
                        addr_q  <= dmem.dmem_rdata;
                        state_q <= ACC;
                        read_q  <= is_read_q;
                        write_q <= ~is_read_q;
                        wmask_q <= is_read_q ? WMASK_NONE : st_wmask;
                        wdata_q <= st_wdata;
                    end
                end
                ACC: begin
                    if (dmem.dmem_resp) begin
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        wmask_q <= WMASK_NONE;
                        if (is_read_q) begin
                            data_q <= ld_data;
                        end
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dmem.dmem_address = {addr_q[15:1], 1'b0};
    assign dmem.dmem_read    = read_q;
    assign dmem.dmem_write   = write_q;
    assign dmem.dmem_wmask   = wmask_q;
    assign dmem.dmem_wdata   = wdata_q;

    assign mem_data_out = data_q;
    assign done         = done_q;
    assign stall        = ((state_q == IDLE) & request) | (state_q == IND) | (state_q == ACC);

endmodule
